// File: rtl/frame_bank_scheduler.sv
// Ping-pong bank scheduler for the two-channel frame FIFO.
// Assigns write banks, validates frames and queues full banks for read-out.
module frame_bank_scheduler #(
   parameter logic [8:0]  FRAME_WORDS = 9'd256,
   parameter logic [15:0] TIMEOUT     = 16'd5600,
   parameter logic [3:0]  CLR_CYCLES  = 4'd4
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iFRAME_START,
   input  logic        iWR_WORD,
   input  logic        iFRAME_END,
   input  logic        iFRAME_ABORT,
   input  logic        iRD_DONE,
   output logic        oWR_GRANT,
   output logic        oSEL_CH_WR,
   output logic [1:0]  oACLR,
   output logic        oFRAME_RDY,
   output logic        oSEL_CH_RD,
   output logic [8:0]  oWORD_CNT,
   output logic        oERR_STB,
   output logic [15:0] oERR_CNT,
   output logic [15:0] oOVERRUN_CNT
);

   typedef enum logic [1:0] {B_FREE, B_FILL, B_READY, B_DRAIN} bankSt_e;
   typedef enum logic [1:0] {W_IDLE, W_FILL, W_CLEAR} wrSt_e;
   typedef enum logic {R_IDLE, R_BUSY} rdSt_e;

   bankSt_e     bank [2];
   bankSt_e     bankNxt [2];
   wrSt_e       wrSt, wrStNxt;
   rdSt_e       rdSt, rdStNxt;
   logic [1:0]  qCnt, qCntNxt;
   logic        q0, q1, q0Nxt, q1Nxt;
   logic        lastFill, lastNxt, prefNxt;
   logic [15:0] timer, timerNxt, timerInc;
   logic [3:0]  clrCnt, clrNxt;
   logic [8:0]  cntNxt;
   logic [1:0]  freeNxt, aclrNxt;
   logic        fail, grantNxt, selWrNxt, selRdNxt;
   logic        rdyNxt, errStbNxt;
   logic [15:0] errCntNxt, ovrCntNxt;

   always_comb begin
      bankNxt[0] = bank[0];
      bankNxt[1] = bank[1];
      wrStNxt    = wrSt;
      rdStNxt    = rdSt;
      qCntNxt    = qCnt;
      q0Nxt      = q0;
      q1Nxt      = q1;
      lastNxt    = lastFill;
      timerInc   = timer + 16'd1;
      timerNxt   = timer;
      clrNxt     = clrCnt;
      cntNxt     = oWORD_CNT;
      fail       = 1'b0;
      selWrNxt   = oSEL_CH_WR;
      selRdNxt   = oSEL_CH_RD;
      rdyNxt     = oFRAME_RDY;
      errStbNxt  = 1'b0;
      errCntNxt  = oERR_CNT;
      ovrCntNxt  = oOVERRUN_CNT;

      // Pop happens before push so a same-cycle push lands behind it.
      unique case (rdSt)
         R_IDLE: begin
            if (qCnt != 2'd0) begin
               selRdNxt      = q0;
               bankNxt[q0]   = B_DRAIN;
               rdyNxt        = 1'b1;
               rdStNxt       = R_BUSY;
               q0Nxt         = q1;
               qCntNxt       = qCnt - 2'd1;
            end
         end
         R_BUSY: begin
            if (iRD_DONE) begin
               bankNxt[oSEL_CH_RD] = B_FREE;
               rdyNxt              = 1'b0;
               rdStNxt             = R_IDLE;
            end
         end
         default: ;
      endcase

      unique case (wrSt)
         W_IDLE: begin
            if (iFRAME_START) begin
               if (oWR_GRANT) begin
                  bankNxt[oSEL_CH_WR] = B_FILL;
                  lastNxt             = oSEL_CH_WR;
                  cntNxt              = 9'd0;
                  timerNxt            = 16'd0;
                  wrStNxt             = W_FILL;
               end else if (oOVERRUN_CNT != 16'hFFFF) begin
                  ovrCntNxt = oOVERRUN_CNT + 16'd1;
               end
            end
         end
         W_FILL: begin
            if (iWR_WORD)
               cntNxt = oWORD_CNT + 9'd1;
            if (iFRAME_ABORT) begin
               fail = 1'b1;
            end else if (iWR_WORD && oWORD_CNT == FRAME_WORDS) begin
               fail = 1'b1;
            end else if (iFRAME_END) begin
               if (cntNxt == FRAME_WORDS) begin
                  bankNxt[oSEL_CH_WR] = B_READY;
                  if (qCntNxt == 2'd0)
                     q0Nxt = oSEL_CH_WR;
                  else
                     q1Nxt = oSEL_CH_WR;
                  qCntNxt = qCntNxt + 2'd1;
                  wrStNxt = W_IDLE;
               end else begin
                  fail = 1'b1;
               end
            end else if (iWR_WORD) begin
               timerNxt = 16'd0;
            end else begin
               timerNxt = timerInc;
               if (timerInc == TIMEOUT)
                  fail = 1'b1;
            end
         end
         W_CLEAR: begin
            clrNxt = clrCnt + 4'd1;
            if (clrCnt == CLR_CYCLES - 4'd1) begin
               bankNxt[oSEL_CH_WR] = B_FREE;
               wrStNxt             = W_IDLE;
            end
         end
         default: ;
      endcase

      if (fail) begin
         wrStNxt   = W_CLEAR;
         clrNxt    = 4'd0;
         errStbNxt = 1'b1;
         if (oERR_CNT != 16'hFFFF)
            errCntNxt = oERR_CNT + 16'd1;
      end

      // Grant and write bank are precomputed from next-cycle bank state.
      freeNxt[0] = (bankNxt[0] == B_FREE);
      freeNxt[1] = (bankNxt[1] == B_FREE);
      prefNxt    = ~lastNxt;
      grantNxt   = (wrStNxt == W_IDLE) && (freeNxt != 2'b00);
      if (wrStNxt == W_IDLE) begin
         if (freeNxt[prefNxt])
            selWrNxt = prefNxt;
         else if (freeNxt[lastNxt])
            selWrNxt = lastNxt;
      end
      aclrNxt = (wrStNxt == W_CLEAR) ? (2'b01 << selWrNxt) : 2'b00;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         bank[0]      <= B_FREE;
         bank[1]      <= B_FREE;
         wrSt         <= W_IDLE;
         rdSt         <= R_IDLE;
         qCnt         <= 2'd0;
         q0           <= 1'b0;
         q1           <= 1'b0;
         lastFill     <= 1'b1;
         timer        <= 16'd0;
         clrCnt       <= 4'd0;
         oWR_GRANT    <= 1'b0;
         oSEL_CH_WR   <= 1'b0;
         oACLR        <= 2'b11;
         oFRAME_RDY   <= 1'b0;
         oSEL_CH_RD   <= 1'b0;
         oWORD_CNT    <= 9'd0;
         oERR_STB     <= 1'b0;
         oERR_CNT     <= 16'd0;
         oOVERRUN_CNT <= 16'd0;
      end else begin
         bank[0]      <= bankNxt[0];
         bank[1]      <= bankNxt[1];
         wrSt         <= wrStNxt;
         rdSt         <= rdStNxt;
         qCnt         <= qCntNxt;
         q0           <= q0Nxt;
         q1           <= q1Nxt;
         lastFill     <= lastNxt;
         timer        <= timerNxt;
         clrCnt       <= clrNxt;
         oWR_GRANT    <= grantNxt;
         oSEL_CH_WR   <= selWrNxt;
         oACLR        <= aclrNxt;
         oFRAME_RDY   <= rdyNxt;
         oSEL_CH_RD   <= selRdNxt;
         oWORD_CNT    <= cntNxt;
         oERR_STB     <= errStbNxt;
         oERR_CNT     <= errCntNxt;
         oOVERRUN_CNT <= ovrCntNxt;
      end
   end

endmodule
